// File: rtl/ps2_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, issues a request-to-send,
// shifts a command byte (LSB first, odd parity) on device clocks and checks the ack.
module ps2_tx #(
   parameter int CLK_FREQ = 28_000_000
) (
   input  logic       clk28,
   input  logic       rst_n,
   input  logic       ps2_clk_in,
   input  logic       ps2_dat_in,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       ps2_clk_oe,
   output logic       ps2_dat_oe,
   output logic       busy,
   output logic       tx_done,
   output logic       tx_error
);

   localparam int     INHIBIT_CYC = CLK_FREQ / 10000;
   localparam int     START_CYC   = CLK_FREQ / 200000;
   localparam longint TIMEOUT_CYC = longint'(CLK_FREQ) * 64'sd15 / 64'sd1000;

   localparam logic [18:0] INHIBIT_LAST = 19'(INHIBIT_CYC - 1);
   localparam logic [18:0] START_LAST   = 19'(START_CYC - 1);
   localparam logic [18:0] TIMEOUT_LAST = 19'(TIMEOUT_CYC - 64'sd1);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_INHIBIT  = 3'd1,
      S_START    = 3'd2,
      S_SHIFT    = 3'd3,
      S_ACK      = 3'd4,
      S_WAITIDLE = 3'd5,
      S_DONE     = 3'd6,
      S_ERROR    = 3'd7
   } state_t;

   // index 0 = clock line, index 1 = data line
   logic [1:0]       r_sync1;
   logic [1:0]       r_sync2;
   logic [1:0]       r_filt;
   logic [1:0][2:0]  r_flt_cnt;
   logic             r_clk_fall;

   state_t      r_state;
   state_t      w_state_nx;
   logic [18:0] r_cnt;
   logic [18:0] w_cnt_nx;
   logic [3:0]  r_bit_cnt;
   logic [3:0]  w_bit_cnt_nx;
   logic [8:0]  r_frame;
   logic [8:0]  w_frame_nx;
   logic        w_dat_oe_nx;
   logic        w_timeout;

   logic r_clk_oe;
   logic r_dat_oe;
   logic r_busy;
   logic r_ready;
   logic r_done;
   logic r_error;

   // Synchronize both lines, then accept a new level only after 8 agreeing samples
   always_ff @(posedge clk28 or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1    <= 2'b11;
         r_sync2    <= 2'b11;
         r_filt     <= 2'b11;
         r_flt_cnt  <= '0;
         r_clk_fall <= 1'b0;
      end else begin
         r_sync1 <= {ps2_dat_in, ps2_clk_in};
         r_sync2 <= r_sync1;
         for (int i = 0; i < 2; i++) begin
            if (r_sync2[i] == r_filt[i]) begin
               r_flt_cnt[i] <= 3'd0;
            end else if (r_flt_cnt[i] == 3'd7) begin
               r_filt[i]    <= r_sync2[i];
               r_flt_cnt[i] <= 3'd0;
            end else begin
               r_flt_cnt[i] <= r_flt_cnt[i] + 3'd1;
            end
         end
         r_clk_fall <= r_filt[0] & ~r_sync2[0] & (r_flt_cnt[0] == 3'd7);
      end
   end

   // Next-state, shared counter and next data-line drive
   always_comb begin
      w_state_nx   = r_state;
      w_cnt_nx     = r_cnt;
      w_bit_cnt_nx = r_bit_cnt;
      w_frame_nx   = r_frame;
      w_dat_oe_nx  = 1'b0;
      w_timeout    = (r_cnt == TIMEOUT_LAST);
      case (r_state)
         S_IDLE: begin
            w_cnt_nx = 19'd0;
            if (tx_valid) begin
               w_frame_nx   = {~^tx_data, tx_data};
               w_bit_cnt_nx = 4'd0;
               w_state_nx   = S_INHIBIT;
            end else begin
               w_state_nx = S_IDLE;
            end
         end
         S_INHIBIT: begin
            if (r_cnt == INHIBIT_LAST) begin
               w_cnt_nx    = 19'd0;
               w_dat_oe_nx = 1'b1;
               w_state_nx  = S_START;
            end else begin
               w_cnt_nx = r_cnt + 19'd1;
            end
         end
         S_START: begin
            // data stays low into SHIFT as the start bit
            w_dat_oe_nx = 1'b1;
            if (r_cnt == START_LAST) begin
               w_cnt_nx   = 19'd0;
               w_state_nx = S_SHIFT;
            end else begin
               w_cnt_nx = r_cnt + 19'd1;
            end
         end
         S_SHIFT: begin
            if (w_timeout) begin
               w_state_nx = S_ERROR;
            end else begin
               w_cnt_nx = r_cnt + 19'd1;
               if (r_clk_fall) begin
                  w_bit_cnt_nx = r_bit_cnt + 4'd1;
                  if (r_bit_cnt == 4'd9) begin
                     w_dat_oe_nx = 1'b0;
                     w_state_nx  = S_ACK;
                  end else begin
                     w_dat_oe_nx = ~r_frame[r_bit_cnt];
                  end
               end else begin
                  w_dat_oe_nx = r_dat_oe;
               end
            end
         end
         S_ACK: begin
            if (w_timeout) begin
               w_state_nx = S_ERROR;
            end else begin
               w_cnt_nx = r_cnt + 19'd1;
               if (r_clk_fall) begin
                  w_state_nx = r_filt[1] ? S_ERROR : S_WAITIDLE;
               end else begin
                  w_state_nx = S_ACK;
               end
            end
         end
         S_WAITIDLE: begin
            if (w_timeout) begin
               w_state_nx = S_ERROR;
            end else begin
               w_cnt_nx = r_cnt + 19'd1;
               if (&r_filt) begin
                  w_state_nx = S_DONE;
               end else begin
                  w_state_nx = S_WAITIDLE;
               end
            end
         end
         S_DONE: begin
            w_cnt_nx   = 19'd0;
            w_state_nx = S_IDLE;
         end
         S_ERROR: begin
            w_cnt_nx   = 19'd0;
            w_state_nx = S_IDLE;
         end
         default: begin
            w_cnt_nx   = 19'd0;
            w_state_nx = S_IDLE;
         end
      endcase
   end

   // State register plus outputs registered from the next state
   always_ff @(posedge clk28 or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_cnt     <= 19'd0;
         r_bit_cnt <= 4'd0;
         r_frame   <= 9'd0;
         r_clk_oe  <= 1'b0;
         r_dat_oe  <= 1'b0;
         r_busy    <= 1'b0;
         r_ready   <= 1'b1;
         r_done    <= 1'b0;
         r_error   <= 1'b0;
      end else begin
         r_state   <= w_state_nx;
         r_cnt     <= w_cnt_nx;
         r_bit_cnt <= w_bit_cnt_nx;
         r_frame   <= w_frame_nx;
         r_clk_oe  <= (w_state_nx == S_INHIBIT) || (w_state_nx == S_START);
         r_dat_oe  <= w_dat_oe_nx;
         r_busy    <= (w_state_nx != S_IDLE);
         r_ready   <= (w_state_nx == S_IDLE);
         r_done    <= (w_state_nx == S_DONE);
         r_error   <= (w_state_nx == S_ERROR);
      end
   end

   assign ps2_clk_oe = r_clk_oe;
   assign ps2_dat_oe = r_dat_oe;
   assign busy       = r_busy;
   assign tx_ready   = r_ready;
   assign tx_done    = r_done;
   assign tx_error   = r_error;

endmodule

// File: tb/tb_ps2_tx.sv
// Bench for ps2_tx: an open-drain PS/2 device model clocks frames out of the DUT and
// compares captured bits, phase lengths and completion pulses with values it derives itself.
module tb_ps2_tx;

   localparam int CLK_FREQ  = 1_400_000;
   localparam int INH_CYC   = CLK_FREQ / 10000;
   localparam int START_CYC = CLK_FREQ / 200000;
   localparam int TO_CYC    = CLK_FREQ * 15 / 1000;
   localparam int HALF      = 40;

   logic       clk28 = 1'b0;
   logic       rst_n;
   logic       dev_clk;
   logic       dev_dat;
   logic       ps2_clk_in;
   logic       ps2_dat_in;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic       ps2_clk_oe;
   logic       ps2_dat_oe;
   logic       busy;
   logic       tx_done;
   logic       tx_error;

   int n_vec  = 0;
   int n_fail = 0;
   int n_done = 0;
   int n_err  = 0;
   logic prev_done = 1'b0;
   logic prev_err  = 1'b0;

   // wired-AND open-drain bus
   assign ps2_clk_in = dev_clk & ~ps2_clk_oe;
   assign ps2_dat_in = dev_dat & ~ps2_dat_oe;

   ps2_tx #(.CLK_FREQ(CLK_FREQ)) dut (
      .clk28      (clk28),
      .rst_n      (rst_n),
      .ps2_clk_in (ps2_clk_in),
      .ps2_dat_in (ps2_dat_in),
      .tx_data    (tx_data),
      .tx_valid   (tx_valid),
      .tx_ready   (tx_ready),
      .ps2_clk_oe (ps2_clk_oe),
      .ps2_dat_oe (ps2_dat_oe),
      .busy       (busy),
      .tx_done    (tx_done),
      .tx_error   (tx_error)
   );

   always #5 clk28 = ~clk28;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Every-cycle rules that hold regardless of which frame is in flight
   always @(negedge clk28) begin
      if (!rst_n) begin
         check("reset_outputs", {ps2_clk_oe, ps2_dat_oe, busy, tx_done, tx_error, tx_ready}, 6'b000001);
      end else begin
         check("ready_is_not_busy", tx_ready, !busy);
         check("done_err_exclusive", tx_done & tx_error, 1'b0);
         check("pulse_one_cycle", (tx_done & prev_done) | (tx_error & prev_err), 1'b0);
         if (!busy || tx_done || tx_error)
            check("lines_released", {ps2_clk_oe, ps2_dat_oe}, 2'b00);
         if (tx_done)  n_done++;
         if (tx_error) n_err++;
      end
      prev_done <= tx_done;
      prev_err  <= tx_error;
   end

   // Request a byte and follow it through inhibit and request-to-send up to clock release
   task automatic accept_and_release(input logic [7:0] d, output int inh, output int st);
      @(negedge clk28);
      tx_data  = d;
      tx_valid = 1'b1;
      @(negedge clk28);
      tx_valid = 1'b0;
      tx_data  = ~d;
      inh = 0;
      while (ps2_clk_oe && !ps2_dat_oe && inh < 4 * INH_CYC) begin
         inh++;
         @(negedge clk28);
      end
      st = 0;
      while (ps2_clk_oe && ps2_dat_oe && st < 4 * INH_CYC) begin
         st++;
         @(negedge clk28);
      end
      check("inhibit_len", inh, INH_CYC);
      check("start_len", st, START_CYC);
      check("start_bit_held", {ps2_clk_oe, ps2_dat_oe}, 2'b01);
   endtask

   // Device side: read start bit, clock 11 times, sample host data before each rising edge
   task automatic dev_frame(input bit ack, input int glitch_after, output logic [10:0] bits);
      bits = '0;
      repeat (20) @(negedge clk28);
      bits[0] = ps2_dat_in;
      for (int i = 1; i <= 11; i++) begin
         dev_clk = 1'b0;
         repeat (HALF) @(negedge clk28);
         if (i <= 10) bits[i] = ps2_dat_in;
         dev_clk = 1'b1;
         if (i == 10 && ack) dev_dat = 1'b0;
         if (i == glitch_after) begin
            repeat (10) @(negedge clk28);
            dev_clk = 1'b0;
            repeat (3) @(negedge clk28);
            dev_clk = 1'b1;
            repeat (HALF - 13) @(negedge clk28);
         end else begin
            repeat (HALF) @(negedge clk28);
         end
      end
      dev_dat = 1'b1;
   endtask

   task automatic run_frame(input logic [7:0] d, input bit ack, input int glitch_after,
                            input logic p_lit, output int inh, output int st,
                            output logic [10:0] bits);
      int dn0;
      int er0;
      int ones;
      logic [10:0] exp_bits;
      dn0 = n_done;
      er0 = n_err;
      accept_and_release(d, inh, st);
      tx_valid = 1'b1;
      tx_data  = 8'h5A;
      @(negedge clk28);
      check("busy_request_ignored", tx_ready, 1'b0);
      tx_valid = 1'b0;
      dev_frame(ack, glitch_after, bits);
      repeat (60) @(negedge clk28);
      ones = 0;
      for (int i = 0; i < 8; i++) ones += int'(d[i]);
      exp_bits = {1'b1, (ones % 2 == 0), d, 1'b0};
      for (int i = 0; i < 11; i++)
         check($sformatf("frame_%02h_bit%0d", d, i), bits[i], exp_bits[i]);
      check("parity_literal", bits[9], p_lit);
      check("done_count", n_done - dn0, ack ? 1 : 0);
      check("error_count", n_err - er0, ack ? 0 : 1);
      check("ready_after_frame", tx_ready, 1'b1);
      check("lines_after_frame", {ps2_clk_oe, ps2_dat_oe}, 2'b00);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: run did not complete in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int inh;
      int st;
      int k;
      int dn0;
      int er0;
      logic [10:0] bits;

      rst_n    = 1'b0;
      dev_clk  = 1'b1;
      dev_dat  = 1'b1;
      tx_valid = 1'b0;
      tx_data  = 8'h00;
      repeat (3) @(negedge clk28);
      rst_n = 1'b1;

      repeat (100) @(negedge clk28);
      check("idle_ready", tx_ready, 1'b1);
      check("idle_busy", busy, 1'b0);
      check("idle_oe", {ps2_clk_oe, ps2_dat_oe}, 2'b00);
      check("idle_no_pulses", n_done + n_err, 0);

      run_frame(8'hED, 1'b1, 0, 1'b1, inh, st, bits);
      check("inhibit_len_literal", inh, 140);
      check("start_len_literal", st, 7);
      check("ed_frame_literal", bits, 11'h7DA);

      run_frame(8'h07, 1'b1, 0, 1'b0, inh, st, bits);
      run_frame(8'h00, 1'b1, 0, 1'b1, inh, st, bits);
      run_frame(8'hFF, 1'b1, 0, 1'b1, inh, st, bits);
      run_frame(8'h96, 1'b0, 0, 1'b1, inh, st, bits);
      run_frame(8'h3C, 1'b1, 4, 1'b1, inh, st, bits);

      // device silent after release: error after the timeout period
      dn0 = n_done;
      er0 = n_err;
      accept_and_release(8'h12, inh, st);
      k = 0;
      while (!tx_error && k < TO_CYC + 100) begin
         k++;
         @(negedge clk28);
      end
      check("timeout_cycles", k, TO_CYC);
      check("timeout_literal", k, 21000);
      check("timeout_lines", {ps2_clk_oe, ps2_dat_oe}, 2'b00);
      repeat (20) @(negedge clk28);
      check("timeout_no_done", n_done - dn0, 0);
      check("timeout_one_error", n_err - er0, 1);

      // reset while bit 4 is on the wire
      accept_and_release(8'hA5, inh, st);
      dn0 = n_done;
      er0 = n_err;
      repeat (20) @(negedge clk28);
      for (int i = 1; i <= 3; i++) begin
         dev_clk = 1'b0;
         repeat (HALF) @(negedge clk28);
         dev_clk = 1'b1;
         repeat (HALF) @(negedge clk28);
      end
      dev_clk = 1'b0;
      repeat (15) @(negedge clk28);
      check("bit4_driven", ps2_dat_oe, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      check("rst_async_oe", {ps2_clk_oe, ps2_dat_oe}, 2'b00);
      check("rst_async_flags", {busy, tx_done, tx_error, tx_ready}, 4'b0001);
      dev_clk = 1'b1;
      repeat (3) @(negedge clk28);
      rst_n = 1'b1;
      repeat (100) @(negedge clk28);
      check("rst_no_pulses", (n_done - dn0) + (n_err - er0), 0);
      check("rst_ready", tx_ready, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
